// File: rtl/midi_tx_if.sv
// Message handshake between a game-event source and the MIDI transmitter.
// master drives a complete message; slave (the transmitter) returns ready.
interface midi_tx_if;
   logic       msg_valid;
   logic       msg_ready;
   logic [7:0] msg_status;
   logic [6:0] msg_data1;
   logic [6:0] msg_data2;
   logic       msg_len2;

   modport master (
      output msg_valid, msg_status, msg_data1, msg_data2, msg_len2,
      input  msg_ready
   );

   modport slave (
      input  msg_valid, msg_status, msg_data1, msg_data2, msg_len2,
      output msg_ready
   );
endinterface

// File: rtl/midi_tx.sv
// MIDI 8N1 serial transmitter with optional running-status compression.
// One message in flight at a time; accepts only while idle.
module midi_tx #(
   parameter int CLKS_PER_BIT   = 2400,
   parameter bit RUNNING_STATUS = 1'b1
) (
   input  logic     clk75MHz,
   input  logic     rst,
   midi_tx_if.slave msg,
   output logic     midi_out,
   output logic     busy,
   output logic     msg_done,
   output logic     msg_err
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_VALID, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
   } state_t;

   state_t      state, state_nxt;
   logic [BW-1:0] baud_cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic [7:0]  status_q;
   logic [6:0]  d1_q, d2_q;
   logic        len2_q;
   logic [1:0]  ptr, ptr_last;
   logic [7:0]  last_status;
   logic        last_vld;
   logic        baud_wrap, accept, is_chan, skip_status;

   assign msg.msg_ready = (state == S_IDLE) && !rst;
   assign accept        = msg.msg_valid && msg.msg_ready;
   assign baud_wrap     = (baud_cnt == BW'(CLKS_PER_BIT - 1));
   assign is_chan       = status_q[7] && (status_q[7:4] != 4'hF);
   assign skip_status   = RUNNING_STATUS && is_chan && last_vld && (status_q == last_status);
   // ptr walks status(0) -> data1(1) -> data2(2); it may start at 1 under running status
   assign ptr_last      = len2_q ? 2'd2 : 2'd1;

   always_ff @(posedge clk75MHz) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      midi_out  = 1'b1;
      busy      = 1'b0;
      msg_done  = 1'b0;
      msg_err   = 1'b0;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_VALID;
         S_VALID: begin
            busy = 1'b1;
            if (!status_q[7]) begin
               msg_err   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            busy      = 1'b1;
            state_nxt = S_START;
         end
         S_START: begin
            busy     = 1'b1;
            midi_out = 1'b0;
            if (baud_wrap) state_nxt = S_DATA;
         end
         S_DATA: begin
            busy     = 1'b1;
            midi_out = shreg[0];
            if (baud_wrap && bit_cnt == 3'd7) state_nxt = S_STOP;
         end
         S_STOP: begin
            busy = 1'b1;
            if (baud_wrap) state_nxt = (ptr == ptr_last) ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            msg_done  = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk75MHz) begin
      if (rst) begin
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         shreg       <= '1;
         ptr         <= '0;
         status_q    <= '0;
         d1_q        <= '0;
         d2_q        <= '0;
         len2_q      <= 1'b0;
         last_status <= '0;
         last_vld    <= 1'b0;
      end else begin
         // bit timing restarts on every state change so each state gets full bit periods
         if (state_nxt != state || baud_wrap) baud_cnt <= '0;
         else                                 baud_cnt <= baud_cnt + 1'b1;

         if (accept) begin
            status_q <= msg.msg_status;
            d1_q     <= msg.msg_data1;
            d2_q     <= msg.msg_data2;
            len2_q   <= msg.msg_len2;
         end

         case (state)
            S_VALID: if (status_q[7]) begin
               ptr      <= skip_status ? 2'd1 : 2'd0;
               last_vld <= is_chan;
               if (is_chan) last_status <= status_q;
            end
            S_LOAD: begin
               bit_cnt <= '0;
               case (ptr)
                  2'd0:    shreg <= status_q;
                  2'd1:    shreg <= {1'b0, d1_q};
                  default: shreg <= {1'b0, d2_q};
               endcase
            end
            S_DATA: if (baud_wrap) begin
               shreg   <= {1'b1, shreg[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
            S_STOP: if (baud_wrap && ptr != ptr_last) ptr <= ptr + 2'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_midi_tx.sv
// Directed bench for midi_tx: vector table of messages decoded off the serial
// line, plus hand sequences for error drop, mid-frame reset and held valid.
module tb_midi_tx;
   localparam int CPB = 4;

   typedef struct {
      int               sel;
      logic [7:0]       st;
      logic [6:0]       d1;
      logic [6:0]       d2;
      logic             len2;
      int               n;
      logic [0:2][7:0]  exp;
   } vec_t;

   logic clk75MHz = 1'b0;
   logic rst      = 1'b1;
   always #5 clk75MHz = ~clk75MHz;

   midi_tx_if if0();
   midi_tx_if if1();
   logic [1:0] midi_out, busy, msg_done, msg_err;

   midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut0 (
      .clk75MHz(clk75MHz), .rst(rst), .msg(if0),
      .midi_out(midi_out[0]), .busy(busy[0]), .msg_done(msg_done[0]), .msg_err(msg_err[0]));
   midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut1 (
      .clk75MHz(clk75MHz), .rst(rst), .msg(if1),
      .midi_out(midi_out[1]), .busy(busy[1]), .msg_done(msg_done[1]), .msg_err(msg_err[1]));

   int n_chk = 0, n_fail = 0;
   int ncyc = 0;
   logic [7:0] rxq0[$], rxq1[$];
   int done_cnt[2], err_cnt[2], done_n[2], start_n[2], frame_err[2];
   bit arm[2];
   vec_t vt[10];

   always @(posedge clk75MHz) ncyc <= ncyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input int s, input logic v, input logic [7:0] st,
                        input logic [6:0] a, input logic [6:0] b, input logic l2);
      if (s == 0) begin
         if0.msg_valid = v; if0.msg_status = st; if0.msg_data1 = a;
         if0.msg_data2 = b; if0.msg_len2 = l2;
      end else begin
         if1.msg_valid = v; if1.msg_status = st; if1.msg_data1 = a;
         if1.msg_data2 = b; if1.msg_len2 = l2;
      end
   endtask

   function automatic logic ready(input int s);
      return (s == 0) ? if0.msg_ready : if1.msg_ready;
   endfunction

   function automatic int qsize(input int s);
      return (s == 0) ? rxq0.size() : rxq1.size();
   endfunction

   function automatic logic [7:0] qget(input int s, input int i);
      if (i >= qsize(s)) return 8'hxx;
      return (s == 0) ? rxq0[i] : rxq1[i];
   endfunction

   task automatic flush(input int s);
      if (s == 0) rxq0.delete();
      else        rxq1.delete();
   endtask

   // UART-style receiver sampling mid-bit on negedges
   task automatic rx_loop(input int s);
      logic [7:0] b;
      bit ok;
      forever begin
         @(negedge clk75MHz);
         if (midi_out[s] === 1'b0) begin
            if (arm[s]) begin start_n[s] = ncyc; arm[s] = 1'b0; end
            ok = 1'b1;
            repeat (CPB / 2) @(negedge clk75MHz);
            if (midi_out[s] !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk75MHz);
               b[i] = midi_out[s];
            end
            repeat (CPB) @(negedge clk75MHz);
            if (midi_out[s] !== 1'b1) ok = 1'b0;
            if (!ok) frame_err[s]++;
            if (s == 0) rxq0.push_back(b);
            else        rxq1.push_back(b);
         end
      end
   endtask

   initial rx_loop(0);
   initial rx_loop(1);

   initial begin : pulse_mon
      forever begin
         @(negedge clk75MHz);
         for (int s = 0; s < 2; s++) begin
            if (msg_done[s] === 1'b1) begin done_cnt[s]++; done_n[s] = ncyc; end
            if (msg_err[s] === 1'b1) err_cnt[s]++;
            if (msg_done[s] === 1'b1 || msg_err[s] === 1'b1)
               check($sformatf("done_err_excl%0d", s), {31'd0, msg_done[s] & msg_err[s]}, 0);
         end
      end
   end

   task automatic run_vec(input vec_t v, input string nm);
      int d0, t, acc_n;
      flush(v.sel);
      d0 = done_cnt[v.sel];
      @(negedge clk75MHz);
      check({nm, "_ready"}, {31'd0, ready(v.sel)}, 1);
      drive(v.sel, 1'b1, v.st, v.d1, v.d2, v.len2);
      arm[v.sel] = 1'b1;
      @(negedge clk75MHz);
      acc_n = ncyc;
      drive(v.sel, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);
      t = 0;
      while (done_cnt[v.sel] == d0 && t < 1000) begin @(negedge clk75MHz); t++; end
      repeat (3) @(negedge clk75MHz);
      check({nm, "_done_once"}, done_cnt[v.sel] - d0, 1);
      check({nm, "_start_lat"}, start_n[v.sel] - acc_n, 2);
      // done lands on the last of the 41*n cycles that begin with the first start bit
      check({nm, "_done_time"}, done_n[v.sel] - start_n[v.sel], 41 * v.n - 1);
      check({nm, "_nbytes"}, qsize(v.sel), v.n);
      for (int i = 0; i < v.n; i++)
         check($sformatf("%s_byte%0d", nm, i), {24'd0, qget(v.sel, i)}, {24'd0, v.exp[i]});
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int d0, e0, t, bad;
      vec_t hv;
      vt[0] = '{0, 8'h90, 7'h3C, 7'h7F, 1'b1, 3, {8'h90, 8'h3C, 8'h7F}};
      vt[1] = '{0, 8'h90, 7'h40, 7'h00, 1'b1, 2, {8'h40, 8'h00, 8'h00}};
      vt[2] = '{0, 8'hC2, 7'h05, 7'h55, 1'b0, 2, {8'hC2, 8'h05, 8'h00}};
      vt[3] = '{0, 8'hC2, 7'h06, 7'h2A, 1'b0, 1, {8'h06, 8'h00, 8'h00}};
      vt[4] = '{0, 8'h90, 7'h3C, 7'h7F, 1'b1, 3, {8'h90, 8'h3C, 8'h7F}};
      vt[5] = '{0, 8'hF8, 7'h00, 7'h00, 1'b0, 2, {8'hF8, 8'h00, 8'h00}};
      vt[6] = '{0, 8'h90, 7'h3C, 7'h40, 1'b1, 3, {8'h90, 8'h3C, 8'h40}};
      vt[7] = '{0, 8'hB0, 7'h07, 7'h64, 1'b1, 3, {8'hB0, 8'h07, 8'h64}};
      vt[8] = '{1, 8'h90, 7'h3C, 7'h7F, 1'b1, 3, {8'h90, 8'h3C, 8'h7F}};
      vt[9] = '{1, 8'h90, 7'h40, 7'h00, 1'b1, 3, {8'h90, 8'h40, 8'h00}};

      drive(0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);
      drive(1, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);

      // reset state
      repeat (3) @(negedge clk75MHz);
      check("rst_ready", {31'd0, if0.msg_ready}, 0);
      check("rst_line", {31'd0, midi_out[0]}, 1);
      check("rst_busy", {31'd0, busy[0]}, 0);
      check("rst_done", {31'd0, msg_done[0]}, 0);
      check("rst_err", {31'd0, msg_err[0]}, 0);
      rst = 1'b0;
      @(negedge clk75MHz);
      check("post_rst_ready", {31'd0, if0.msg_ready}, 1);

      for (int i = 0; i < 10; i++) run_vec(vt[i], $sformatf("v%0d", i));

      // invalid status byte is dropped; last_status (0xB0) survives it
      flush(0);
      e0 = err_cnt[0];
      d0 = done_cnt[0];
      @(negedge clk75MHz);
      drive(0, 1'b1, 8'h3C, 7'h11, 7'h22, 1'b1);
      @(negedge clk75MHz);
      drive(0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);
      check("err_pulse", {31'd0, msg_err[0]}, 1);
      @(negedge clk75MHz);
      check("err_ready_back", {31'd0, if0.msg_ready}, 1);
      check("err_oneshot", {31'd0, msg_err[0]}, 0);
      repeat (50) @(negedge clk75MHz);
      check("err_count", err_cnt[0] - e0, 1);
      check("err_line_quiet", rxq0.size(), 0);
      check("err_no_done", done_cnt[0] - d0, 0);
      hv = '{0, 8'hB0, 7'h07, 7'h10, 1'b1, 2, {8'h07, 8'h10, 8'h00}};
      run_vec(hv, "after_err");

      // reset during data bit 3 of the second byte
      flush(0);
      d0 = done_cnt[0];
      @(negedge clk75MHz);
      drive(0, 1'b1, 8'h90, 7'h3C, 7'h7F, 1'b1);
      @(negedge clk75MHz);
      drive(0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);
      t = 0;
      while (midi_out[0] !== 1'b0 && t < 20) begin @(negedge clk75MHz); t++; end
      check("mid_start_seen", {31'd0, midi_out[0]}, 0);
      repeat (41 + CPB + 3 * CPB + 1) @(negedge clk75MHz);
      rst = 1'b1;
      @(negedge clk75MHz);
      check("mid_rst_line", {31'd0, midi_out[0]}, 1);
      check("mid_rst_ready", {31'd0, if0.msg_ready}, 0);
      check("mid_rst_busy", {31'd0, busy[0]}, 0);
      rst = 1'b0;
      @(negedge clk75MHz);
      check("mid_rst_ready_back", {31'd0, if0.msg_ready}, 1);
      repeat (60) @(negedge clk75MHz);
      check("mid_rst_no_done", done_cnt[0] - d0, 0);
      flush(0);
      run_vec(vt[0], "post_mid_rst");

      // valid held through a busy message must not sneak in a second one
      flush(0);
      d0 = done_cnt[0];
      @(negedge clk75MHz);
      drive(0, 1'b1, 8'h90, 7'h40, 7'h01, 1'b1);
      @(negedge clk75MHz);
      drive(0, 1'b1, 8'h80, 7'h11, 7'h22, 1'b1);
      bad = 0;
      t = 0;
      while (msg_done[0] !== 1'b1 && t < 1000) begin
         if (if0.msg_ready !== 1'b0) bad++;
         @(negedge clk75MHz);
         t++;
      end
      drive(0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);
      check("hold_done_seen", {31'd0, msg_done[0]}, 1);
      check("hold_ready_low", bad, 0);
      repeat (60) @(negedge clk75MHz);
      check("hold_nbytes", rxq0.size(), 2);
      check("hold_byte0", {24'd0, qget(0, 0)}, 32'h40);
      check("hold_byte1", {24'd0, qget(0, 1)}, 32'h01);
      check("hold_done_once", done_cnt[0] - d0, 1);

      check("frame_errors", frame_err[0] + frame_err[1], 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Serial MIDI transmitter: the transmit-side counterpart of the game's MIDI receive path (serial-to-parallel plus controller decode).
- Accepts complete MIDI channel/system messages over a valid/ready handshake and serializes them 8N1 at 31250 baud on a single output line.
- Applies MIDI running-status compression.
- Intended use: sending game events to an external synth, e.g. a Note On on collision or a Control Change carrying the score.

Parameters:
- CLKS_PER_BIT, 2400, clk75MHz cycles per serial bit (75 MHz / 31250 baud); bench uses 4
- RUNNING_STATUS, 1, 1 = omit the status byte when it repeats, 0 = always send status

Ports:
- clk75MHz  input  1  system clock
- rst  input  1  synchronous active-high reset
- msg_valid  input  1  message offered
- msg_ready  output  1  transmitter can accept a message this cycle
- msg_status  input  8  status byte; bit7 must be 1
- msg_data1  input  7  first data byte (sent with bit7 = 0)
- msg_data2  input  7  second data byte (sent with bit7 = 0)
- msg_len2  input  1  1 = two data bytes, 0 = one data byte (program change, channel pressure)
- midi_out  output  1  serial line, idle high
- busy  output  1  high while any byte of a message is being shifted
- msg_done  output  1  one-cycle pulse after the last stop bit of a message
- msg_err  output  1  one-cycle pulse when a message is dropped

Behaviour:
- Clock and reset: one clock (clk75MHz); reset is synchronous and active-high (rst).
- Reset values: midi_out=1, msg_ready=0 during rst then 1 in the first cycle after, busy=0, msg_done=0, msg_err=0, last_status=none (invalid), FSM=IDLE, bit counter and baud counter=0.
- Handshake: a message transfers on a clock edge with msg_valid & msg_ready. All msg_* inputs are latched at that edge. msg_ready=1 only in IDLE, so a new message never overlaps one in flight. msg_valid held while busy is ignored and not queued.
- Validation, in the cycle after acceptance:
  - msg_status[7]=0 -> message dropped, msg_err pulses 1 cycle, line stays high, last_status unchanged, back to IDLE.
- Byte list:
  - status byte is included unless RUNNING_STATUS=1, msg_status is in 0x80..0xEF, and msg_status==last_status;
  - then data1;
  - then data2 if msg_len2=1.
  - Data byte bit7 is forced to 0.
- Running status update:
  - after a channel message (0x80..0xEF) is accepted, last_status=msg_status;
  - a system message (0xF0..0xFF) clears last_status to none and is always sent with its status byte.
- FSM states: IDLE -> LOAD -> START -> DATA -> STOP -> (LOAD if bytes remain, else DONE) -> IDLE.
  - LOAD: one cycle, selects the next byte into the shift register.
  - START: midi_out=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP: midi_out=1 for CLKS_PER_BIT cycles.
  - DONE: msg_done=1 for one cycle, busy deasserts in the same cycle.
- Latency: midi_out falls (start bit) exactly 2 cycles after the accept edge (validate, then LOAD). Between bytes there is 1 extra high cycle (LOAD) after the stop bit. A byte occupies 10*CLKS_PER_BIT cycles plus 1.
- Baud counter: counts 0..CLKS_PER_BIT-1, advances a bit on the wrap, and is reset to 0 on every state entry. No fractional-baud accumulation is required.
- busy is 1 from the validation cycle through the STOP of the last byte.
- Reset mid-operation: the next cycle drives midi_out=1 (a truncated frame is acceptable), last_status is cleared, and the FSM goes to IDLE.
- msg_err and msg_done are never both asserted in the same cycle.

Test Plan:
- CLKS_PER_BIT=4; send 0x90,0x3C,0x7F, len2=1 -> three frames 0x90,0x3C,0x7F, LSB first, start=0, stop=1; first start bit 2 cycles after accept; msg_done pulses once, 3*41 cycles after the first start bit.
- Repeat 0x90,0x40,0x00 right after -> only 0x40,0x00 are sent (running status); 0x90 again with RUNNING_STATUS=0 -> 3 bytes.
- Send 0xC2,0x05 with len2=0, then 0xC2,0x06 -> first message sends 0xC2,0x05; second sends 0x06 only; data2 is never sent.
- Send 0x90 message, then system 0xF8 (len2=0, data1=0x00), then 0x90 again -> status 0x90 resent after the system message.
- msg_status=0x3C -> msg_err 1 cycle, midi_out stays high, msg_ready back to 1 within 2 cycles, last_status unchanged.
- Assert rst during data bit 3 of the second byte -> midi_out=1 the next cycle; msg_ready=1 after rst falls; next 0x90 message sends its status byte. Hold msg_valid during busy -> msg_ready=0 and no second message is captured.
